// File: rtl/sad_stream_engine.sv
// ---------------------------------------------------------------------------
// sad_stream_engine
//
// Streaming block SAD engine. One row of BLK_W pixel pairs is accepted per
// cycle. Each row goes through a registered abs-diff stage and a registered
// binary adder tree (LOG2W levels). The row sums are then accumulated over
// BLK_H rows into one block SAD. Output backpressure stalls the whole
// pipeline.
//
// Optional feature (define SAD_MIN_SEARCH_EN): tracks the minimum block SAD
// over a window of CAND_NUM consecutive blocks and reports it together with
// the SAD of the window's last block.
//
// Ports:
//   clk      : clock; all logic on the rising edge
//   rstn     : asynchronous active-low reset
//   clr      : synchronous flush of pipeline valids, accumulator, row and
//              candidate counters, sad_vld and best_vld
//   din      : current-block row; pixel k at [k*DWIDTH +: DWIDTH]
//   refi     : reference row, same packing
//   in_vld   : row valid
//   in_rdy   : engine can accept a row
//   sad      : block SAD
//   sad_vld  : sad valid
//   sad_rdy  : downstream accepts sad
//   best_sad : minimum SAD over the window        (SAD_MIN_SEARCH_EN only)
//   best_idx : candidate index of best_sad        (SAD_MIN_SEARCH_EN only)
//   best_vld : qualifies best_sad / best_idx      (SAD_MIN_SEARCH_EN only)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A source holds valid and its data stable until that edge, and
// valid never depends on ready. On the input side the engine is the sink
// (in_vld/in_rdy). On the output side it is the source (sad_vld/sad_rdy).
// best_* ride on the sad_vld/sad_rdy transfer.
// ---------------------------------------------------------------------------
module sad_stream_engine #(
    parameter int DWIDTH   = 8,
    parameter int BLK_W    = 16,
    parameter int BLK_H    = 16,
    parameter int CAND_NUM = 4,
    localparam int LOG2W   = $clog2(BLK_W),
    localparam int SWIDTH  = DWIDTH + LOG2W + $clog2(BLK_H),
    localparam int IWIDTH  = (CAND_NUM > 1) ? $clog2(CAND_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clr,
    input  logic [BLK_W*DWIDTH-1:0] din,
    input  logic [BLK_W*DWIDTH-1:0] refi,
    input  logic                    in_vld,
    output logic                    in_rdy,
    output logic [SWIDTH-1:0]       sad,
    output logic                    sad_vld,
`ifdef SAD_MIN_SEARCH_EN
    output logic [SWIDTH-1:0]       best_sad,
    output logic [IWIDTH-1:0]       best_idx,
    output logic                    best_vld,
`endif
    input  logic                    sad_rdy
);

    // The tree is kept at its final width on every level. The sum cannot
    // overflow, and indexing stays uniform across levels.
    localparam int TW = DWIDTH + LOG2W;
    localparam int CW = (BLK_H > 1) ? $clog2(BLK_H) : 1;

    logic              adv;
    logic              accept;
    logic              last_row;
    logic [CW-1:0]     row_cnt;

    logic [DWIDTH:0]   diff;
    logic [DWIDTH-1:0] ad_d [BLK_W];
    logic [DWIDTH-1:0] ad_q [BLK_W];
    logic [TW-1:0]     sum_q [1:LOG2W][BLK_W/2];

    // Bit 0 belongs to the abs-diff stage; bit L belongs to tree level L.
    logic [LOG2W:0]    v_q;
    logic [LOG2W:0]    t_q;

    logic [TW-1:0]     rowsum;
    logic [SWIDTH-1:0] acc;
    logic [SWIDTH-1:0] sad_next;
    logic              blk_done;

    // Global stall: nothing moves while a completed SAD is still waiting.
    assign adv    = ~sad_vld | sad_rdy;
    // A row presented during clr is dropped, so accepting it is harmless.
    // Holding in_rdy high keeps the upstream fetch from stalling on a flush.
    assign in_rdy = adv | clr;
    assign accept = in_vld & adv & ~clr;

    assign last_row = (row_cnt == CW'(BLK_H - 1));

    // Row counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt <= '0;
        end else if (clr) begin
            row_cnt <= '0;
        end else if (accept) begin
            row_cnt <= last_row ? '0 : row_cnt + CW'(1);
        end
    end

    // Stage 0: per-pixel absolute difference. The extra sign bit of the
    // (DWIDTH+1)-bit difference selects negation.
    always_comb begin
        diff = '0;
        for (int k = 0; k < BLK_W; k++) begin
            diff    = {1'b0, din[k*DWIDTH +: DWIDTH]} - {1'b0, refi[k*DWIDTH +: DWIDTH]};
            ad_d[k] = diff[DWIDTH] ? DWIDTH'(-diff) : DWIDTH'(diff);
        end
    end

    // Datapath registers: abs-diff stage plus adder tree. Data moves on every
    // advancing edge. Whether it means anything is carried by v_q alone.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < BLK_W; k++) begin
                ad_q[k] <= '0;
            end
            for (int l = 1; l <= LOG2W; l++) begin
                for (int k = 0; k < BLK_W/2; k++) begin
                    sum_q[l][k] <= '0;
                end
            end
        end else if (adv) begin
            for (int k = 0; k < BLK_W; k++) begin
                ad_q[k] <= ad_d[k];
            end
            for (int k = 0; k < BLK_W/2; k++) begin
                sum_q[1][k] <= TW'(ad_q[2*k]) + TW'(ad_q[2*k+1]);
            end
            for (int l = 2; l <= LOG2W; l++) begin
                for (int k = 0; k < (BLK_W >> l); k++) begin
                    sum_q[l][k] <= sum_q[l-1][2*k] + sum_q[l-1][2*k+1];
                end
            end
        end
    end

    // Valid and last-row tags travel alongside the data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
            t_q <= '0;
        end else if (clr) begin
            v_q <= '0;
            t_q <= '0;
        end else if (adv) begin
            v_q <= {v_q[LOG2W-1:0], in_vld};
            t_q <= {t_q[LOG2W-1:0], last_row};
        end
    end

    assign rowsum   = sum_q[LOG2W][0];
    assign sad_next = acc + SWIDTH'(rowsum);
    assign blk_done = v_q[LOG2W] & t_q[LOG2W];

    // Final stage: row accumulation and block output. sad_vld is rewritten on
    // every advancing edge. It therefore drops after a handshake unless a new
    // block completes on that same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc     <= '0;
            sad     <= '0;
            sad_vld <= 1'b0;
        end else if (clr) begin
            acc     <= '0;
            sad_vld <= 1'b0;
        end else if (adv) begin
            sad_vld <= blk_done;
            if (v_q[LOG2W]) begin
                if (t_q[LOG2W]) begin
                    sad <= sad_next;
                    acc <= '0;
                end else begin
                    acc <= sad_next;
                end
            end
        end
    end

`ifdef SAD_MIN_SEARCH_EN
    logic [IWIDTH-1:0] cand_cnt;
    logic              cand_last;

    assign cand_last = (cand_cnt == IWIDTH'(CAND_NUM - 1));

    // Candidate 0 always loads. Later candidates replace the best only on a
    // strictly smaller SAD, so a tie keeps the earlier index.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cand_cnt <= '0;
            best_sad <= '0;
            best_idx <= '0;
            best_vld <= 1'b0;
        end else if (clr) begin
            cand_cnt <= '0;
            best_vld <= 1'b0;
        end else if (adv) begin
            best_vld <= blk_done & cand_last;
            if (blk_done) begin
                if ((cand_cnt == '0) || (sad_next < best_sad)) begin
                    best_sad <= sad_next;
                    best_idx <= cand_cnt;
                end
                cand_cnt <= cand_last ? '0 : cand_cnt + IWIDTH'(1);
            end
        end
    end
`else
    // CAND_NUM only shapes the search path. It is referenced here so that it
    // remains a meaningful parameter of the default build.
    if (CAND_NUM < 1) begin : g_cand_num_unused
    end
    if (IWIDTH < 1) begin : g_iwidth_unused
    end
`endif

endmodule

// File: tb/tb_sad_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_sad_stream_engine
//
// Directed bench for sad_stream_engine with its default parameters
// (8-bit pixels, 16x16 blocks, 4 candidates). Expected block SADs are
// computed by hand and queued when a block is issued. A monitor pops the
// queue and compares on every sad_vld/sad_rdy transfer.
// ---------------------------------------------------------------------------
module tb_sad_stream_engine;

    localparam int DWIDTH   = 8;
    localparam int BLK_W    = 16;
    localparam int BLK_H    = 16;
    localparam int CAND_NUM = 4;
    localparam int SWIDTH   = 16;
    localparam int IWIDTH   = 2;
    localparam int W        = BLK_W * DWIDTH;

    logic              clk;
    logic              rstn;
    logic              clr;
    logic [W-1:0]      din;
    logic [W-1:0]      refi;
    logic              in_vld;
    logic              in_rdy;
    logic [SWIDTH-1:0] sad;
    logic              sad_vld;
    logic              sad_rdy;
`ifdef SAD_MIN_SEARCH_EN
    logic [SWIDTH-1:0] best_sad;
    logic [IWIDTH-1:0] best_idx;
    logic              best_vld;
`endif

    logic [SWIDTH-1:0] exp_q[$];
    int n_checks;
    int n_errors;

    sad_stream_engine #(
        .DWIDTH  (DWIDTH),
        .BLK_W   (BLK_W),
        .BLK_H   (BLK_H),
        .CAND_NUM(CAND_NUM)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .din     (din),
        .refi    (refi),
        .in_vld  (in_vld),
        .in_rdy  (in_rdy),
        .sad     (sad),
        .sad_vld (sad_vld),
`ifdef SAD_MIN_SEARCH_EN
        .best_sad(best_sad),
        .best_idx(best_idx),
        .best_vld(best_vld),
`endif
        .sad_rdy (sad_rdy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Presents one row and returns just after the edge that accepted it,
    // leaving in_vld high so consecutive calls stream without bubbles.
    task automatic send_row(input logic [W-1:0] d, input logic [W-1:0] r);
        bit taken;
        int waits;
        din    = d;
        refi   = r;
        in_vld = 1'b1;
        taken  = 1'b0;
        waits  = 0;
        while (!taken) begin
            @(negedge clk);
            taken = in_rdy;
            @(posedge clk);
            #1;
            waits++;
            if (!taken && waits > 100) begin
                n_checks++;
                n_errors++;
                $display("FAIL row_accept_timeout: got no in_rdy in %0d cycles, expected acceptance", waits);
                taken = 1'b1;
            end
        end
    endtask

    // One block whose SAD comes only from pixel 0 (din=v, refi=0).
    // The other pixels carry equal random bytes. The total is spread over
    // the 16 rows.
    task automatic send_block_pix0(input int total);
        logic [W-1:0] d;
        logic [W-1:0] r;
        int v;
        for (int i = 0; i < BLK_H; i++) begin
            v = total / BLK_H + ((i < total % BLK_H) ? 1 : 0);
            for (int k = 0; k < BLK_W; k++) r[k*DWIDTH +: DWIDTH] = 8'($urandom_range(0, 255));
            d = r;
            d[DWIDTH-1:0] = 8'(v);
            r[DWIDTH-1:0] = 8'h00;
            send_row(d, r);
        end
    endtask

    task automatic send_pix_rows(input int n, input logic [7:0] dv, input logic [7:0] rv);
        logic [W-1:0] d;
        logic [W-1:0] r;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < BLK_W; k++) r[k*DWIDTH +: DWIDTH] = 8'($urandom_range(0, 255));
            d = r;
            d[DWIDTH-1:0] = dv;
            r[DWIDTH-1:0] = rv;
            send_row(d, r);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rstn && sad_vld && sad_rdy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_sad: got sad=%0d, expected no output", sad);
            end else begin
                check("block_sad", 32'(sad), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        rstn     = 1'b0;
        clr      = 1'b0;
        in_vld   = 1'b0;
        din      = '0;
        refi     = '0;
        sad_rdy  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_rdy", in_rdy, 1);
        check("reset_sad", sad, 0);
        check("reset_sad_vld", sad_vld, 0);
`ifdef SAD_MIN_SEARCH_EN
        check("reset_best_sad", best_sad, 0);
        check("reset_best_idx", best_idx, 0);
        check("reset_best_vld", best_vld, 0);
`endif

        // Full-scale block: 256 pixels * 255, and pipeline latency.
        exp_q.push_back(16'd65280);
        for (int i = 0; i < BLK_H; i++) send_row({BLK_W{8'hFF}}, '0);
        in_vld = 1'b0;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (sad_vld) break;
        end
        check("latency_edges", n, 5);
        @(posedge clk);
        #1;
        check("sad_vld_single_pulse", sad_vld, 0);
        wait_drain();

        // Pixel 0 only, both signs of the difference: |0x10-0x30|*16 = 512.
        exp_q.push_back(16'd512);
        send_pix_rows(BLK_H, 8'h10, 8'h30);
        exp_q.push_back(16'd512);
        send_pix_rows(BLK_H, 8'h30, 8'h10);
        in_vld = 1'b0;
        wait_drain();

        // Back-to-back blocks with 10 cycles of output backpressure.
        fork
            begin
                exp_q.push_back(16'd100);
                send_block_pix0(100);
                exp_q.push_back(16'd200);
                send_block_pix0(200);
                in_vld = 1'b0;
            end
            begin
                int t;
                t = 0;
                while (!sad_vld && t < 200) begin
                    @(posedge clk);
                    #1;
                    t++;
                end
                check("stall_first_sad_seen", sad_vld, 1);
                sad_rdy = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("stall_in_rdy", in_rdy, 0);
                    check("stall_sad_held", sad, 100);
                end
                @(posedge clk);
                #1;
                sad_rdy = 1'b1;
            end
        join
        wait_drain();

        // clr at row 7 with a row presented: aborted block never emerges.
        send_pix_rows(7, 8'd9, 8'd0);
        din    = {BLK_W{8'h44}};
        refi   = '0;
        in_vld = 1'b1;
        clr    = 1'b1;
        @(negedge clk);
        check("clr_in_rdy", in_rdy, 1);
        @(posedge clk);
        #1;
        clr    = 1'b0;
        in_vld = 1'b0;
        exp_q.push_back(16'd50);
        send_block_pix0(50);
        in_vld = 1'b0;
        wait_drain();

        // Asynchronous reset at row 9: outputs clear immediately.
        send_pix_rows(9, 8'd5, 8'd0);
        in_vld = 1'b0;
        rstn   = 1'b0;
        #1;
        check("async_rst_sad", sad, 0);
        check("async_rst_sad_vld", sad_vld, 0);
        check("async_rst_in_rdy", in_rdy, 1);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(16'd700);
        send_block_pix0(700);
        in_vld = 1'b0;
        wait_drain();

`ifdef SAD_MIN_SEARCH_EN
        // Candidate window 300, 120, 120, 500: best is 120 at index 1.
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        fork
            begin
                exp_q.push_back(16'd300);
                send_block_pix0(300);
                exp_q.push_back(16'd120);
                send_block_pix0(120);
                exp_q.push_back(16'd120);
                send_block_pix0(120);
                exp_q.push_back(16'd500);
                send_block_pix0(500);
                in_vld = 1'b0;
            end
            begin
                int k;
                int t;
                k = 0;
                t = 0;
                while (k < CAND_NUM && t < 500) begin
                    @(negedge clk);
                    t++;
                    if (sad_vld && sad_rdy) begin
                        check("best_vld_per_block", best_vld, (k == CAND_NUM - 1) ? 1 : 0);
                        if (k == CAND_NUM - 1) begin
                            check("best_sad", best_sad, 120);
                            check("best_idx", best_idx, 1);
                        end
                        k++;
                    end
                end
                check("search_blocks_seen", k, CAND_NUM);
            end
        join
        wait_drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
